writeback_unit: RTL and testbench

- Write-side master for the integer register file. Collects results from three producers and drives the file's single write port (we/rd/rd_data) with registered outputs:
  - ALU: single-cycle, no handshake.
  - Load/store unit (LSU): valid/ready handshake.
  - Multiply/divide unit (MDU): valid/ready handshake.
- Formats load data, i.e. byte/halfword extraction and sign/zero extension.
- Keeps a pending-destination scoreboard that decode uses for RAW hazard stalls on long-latency ops.

---
 rtl/writeback_unit.sv | 137 +++++++++++++
 tb/tb_writeback_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_unit.sv
// writeback_unit: write-side master for the integer register file.
//   Arbitrates ALU (no handshake), LSU and MDU (valid/ready) onto one write port,
//   formats load data, and tracks pending long-latency destinations for decode.
// Latency: wb_we/wb_rd/wb_data are registered, one cycle after grant.
// Backpressure: ALU is held with alu_stall; LSU/MDU see ready only in their grant cycle.
// Ports: clk/rst_n; issue_valid/issue_rd -> busy_mask; alu_*; lsu_*; mdu_*; wb_we/wb_rd/wb_data.
module writeback_unit #(
  parameter int XLEN           = 32,
  parameter int ALU_STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  output logic [31:0]     busy_mask,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_stall,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  input  logic [2:0]      lsu_funct3,
  input  logic [1:0]      lsu_addr_lo,
  input  logic            mdu_valid,
  output logic            mdu_ready,
  input  logic [4:0]      mdu_rd,
  input  logic [XLEN-1:0] mdu_data,
  output logic            wb_we,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data
);

  localparam int SW = $clog2(ALU_STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(ALU_STARVE_MAX);

  logic [SW-1:0]   starve_q, starve_d;
  logic            rr_q, rr_d;          // 0: LSU preferred, 1: MDU preferred
  logic [31:0]     busy_q, busy_d;
  logic            wb_we_q, wb_we_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;

  logic            hs_any, force_hs, alu_gnt, lsu_gnt, mdu_gnt;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_fmt;
  logic [31:0]     busy_set, busy_clr;

  // Grant: ALU has priority until it has starved a waiting handshake source
  // for ALU_STARVE_MAX cycles; LSU/MDU contention resolved by the rr pointer.
  always_comb begin
    hs_any   = lsu_valid || mdu_valid;
    force_hs = hs_any && (starve_q == STARVE_MAX);
    alu_gnt  = alu_valid && !force_hs;
    lsu_gnt  = !alu_gnt && lsu_valid && (!mdu_valid || !rr_q);
    mdu_gnt  = !alu_gnt && mdu_valid && (!lsu_valid || rr_q);
  end

  assign alu_stall = alu_valid && !alu_gnt;
  assign lsu_ready = lsu_gnt;
  assign mdu_ready = mdu_gnt;

  // Load formatting; the half select ignores addr_lo[0].
  always_comb begin
    ld_byte = lsu_data[8*lsu_addr_lo +: 8];
    ld_half = lsu_addr_lo[1] ? lsu_data[31:16] : lsu_data[15:0];
    case (lsu_funct3)
      3'b000:  ld_fmt = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_fmt = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b100:  ld_fmt = {{(XLEN-8){1'b0}}, ld_byte};
      3'b101:  ld_fmt = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_fmt = lsu_data;
    endcase
  end

  // Next-state: output register, starve counter, rr pointer, scoreboard.
  always_comb begin
    wb_we_d   = 1'b0;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    if (alu_gnt) begin
      wb_rd_d   = alu_rd;
      wb_data_d = alu_data;
    end else if (lsu_gnt) begin
      wb_rd_d   = lsu_rd;
      wb_data_d = ld_fmt;
    end else if (mdu_gnt) begin
      wb_rd_d   = mdu_rd;
      wb_data_d = mdu_data;
    end
    // x0 grants complete the handshake but never write.
    wb_we_d = (alu_gnt || lsu_gnt || mdu_gnt) && (wb_rd_d != 5'd0);

    starve_d = starve_q;
    if (lsu_gnt || mdu_gnt || !hs_any) begin
      starve_d = '0;
    end else if (alu_gnt && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + 1'b1;
    end

    rr_d = (lsu_gnt || mdu_gnt) ? !rr_q : rr_q;

    busy_clr = 32'd0;
    if (lsu_gnt) busy_clr = busy_clr | (32'd1 << lsu_rd);
    if (mdu_gnt) busy_clr = busy_clr | (32'd1 << mdu_rd);
    busy_set = issue_valid ? (32'd1 << issue_rd) : 32'd0;
    // Set applied after clear so a same-cycle reissue of rd stays busy.
    busy_d    = (busy_q & ~busy_clr) | busy_set;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_we_q   <= 1'b0;
      wb_rd_q   <= 5'd0;
      wb_data_q <= '0;
      starve_q  <= '0;
      rr_q      <= 1'b0;
      busy_q    <= 32'd0;
    end else begin
      wb_we_q   <= wb_we_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
      starve_q  <= starve_d;
      rr_q      <= rr_d;
      busy_q    <= busy_d;
    end
  end

  assign wb_we     = wb_we_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign busy_mask = busy_q;

endmodule

// File: tb/tb_writeback_unit.sv
module tb_writeback_unit;

  localparam int MAXS = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rd = 5'd0;
  logic [31:0] busy_mask;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = 5'd0;
  logic [31:0] alu_data = 32'd0;
  logic        alu_stall;
  logic        lsu_valid = 1'b0;
  logic        lsu_ready;
  logic [4:0]  lsu_rd = 5'd0;
  logic [31:0] lsu_data = 32'd0;
  logic [2:0]  lsu_funct3 = 3'd0;
  logic [1:0]  lsu_addr_lo = 2'd0;
  logic        mdu_valid = 1'b0;
  logic        mdu_ready;
  logic [4:0]  mdu_rd = 5'd0;
  logic [31:0] mdu_data = 32'd0;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  writeback_unit #(.XLEN(32), .ALU_STARVE_MAX(MAXS)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .busy_mask(busy_mask),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .lsu_funct3(lsu_funct3), .lsu_addr_lo(lsu_addr_lo),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  int          m_starve;
  bit          m_prefer_mdu;
  logic [31:0] m_busy;
  logic        m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  bit          m_known;       // m_rd/m_data are defined
  int          last_winner;   // 0 none, 1 ALU, 2 LSU, 3 MDU

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] load_value(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] a);
    int unsigned b, h;
    b = (w >> (8 * a)) & 32'hFF;
    h = (w >> (16 * (a / 2))) & 32'hFFFF;
    case (f3)
      3'd0: return (b >= 128) ? 32'(b) - 32'd256 : 32'(b);
      3'd1: return (h >= 32768) ? 32'(h) - 32'd65536 : 32'(h);
      3'd4: return 32'(b);
      3'd5: return 32'(h);
      default: return w;
    endcase
  endfunction

  task automatic model_reset();
    m_starve = 0; m_prefer_mdu = 0; m_busy = 0;
    m_we = 0; m_rd = 0; m_data = 0; m_known = 1; last_winner = 0;
  endtask

  // Evaluate one cycle: inputs already driven at posedge+1.
  task automatic step();
    int w;
    bit waiting;
    #1;
    waiting = lsu_valid || mdu_valid;
    w = 0;
    if (alu_valid && !(m_starve == MAXS && waiting)) w = 1;
    else if (lsu_valid && mdu_valid) w = m_prefer_mdu ? 3 : 2;
    else if (lsu_valid) w = 2;
    else if (mdu_valid) w = 3;
    check("lsu_ready", 32'(lsu_ready), 32'(w == 2));
    check("mdu_ready", 32'(mdu_ready), 32'(w == 3));
    check("alu_stall", 32'(alu_stall), 32'(alu_valid && w != 1));

    if (w >= 2 || !waiting) m_starve = 0;
    else if (w == 1 && m_starve < MAXS) m_starve++;
    if (w >= 2) m_prefer_mdu = !m_prefer_mdu;
    if (w == 2) m_busy[lsu_rd] = 1'b0;
    if (w == 3) m_busy[mdu_rd] = 1'b0;
    if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;

    m_we = 0;
    if (w != 0) begin
      logic [4:0] r;
      logic [31:0] d;
      r = (w == 1) ? alu_rd : (w == 2) ? lsu_rd : mdu_rd;
      d = (w == 1) ? alu_data : (w == 2) ? load_value(lsu_data, lsu_funct3, lsu_addr_lo) : mdu_data;
      if (r != 0) begin m_we = 1; m_rd = r; m_data = d; m_known = 1; end
      else m_known = 0;
    end
    last_winner = w;

    @(posedge clk); #1;
    check("wb_we", 32'(wb_we), 32'(m_we));
    if (m_known) begin
      check("wb_rd", 32'(wb_rd), 32'(m_rd));
      check("wb_data", wb_data, m_data);
    end
    check("busy_mask", busy_mask, m_busy);
  endtask

  // Producer behaviour: hold an offered result until accepted.
  // mode 0: random; 1: LSU+MDU always valid, ALU idle; 2: ALU+MDU always valid.
  task automatic next_inputs(input int mode);
    if (!lsu_valid || last_winner == 2) begin
      lsu_valid   = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      lsu_rd      = 5'($urandom_range(0, 9));
      lsu_data    = $urandom;
      lsu_funct3  = 3'($urandom_range(0, 7));
      lsu_addr_lo = 2'($urandom_range(0, 3));
    end
    if (!mdu_valid || last_winner == 3) begin
      mdu_valid = (mode != 0) ? 1'b1 : 1'($urandom_range(0, 1));
      mdu_rd    = 5'($urandom_range(0, 9));
      mdu_data  = $urandom;
    end
    if (!alu_valid || last_winner == 1) begin
      alu_valid = (mode == 2) ? 1'b1 : (mode == 1) ? 1'b0 : 1'($urandom_range(0, 3) != 0);
      alu_rd    = 5'($urandom_range(0, 9));
      alu_data  = $urandom;
    end
    issue_valid = (mode == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
    issue_rd    = 5'($urandom_range(0, 9));
  endtask

  task automatic idle_inputs();
    alu_valid = 0; lsu_valid = 0; mdu_valid = 0; issue_valid = 0;
  endtask

  logic [2:0] ld_f3 [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
  logic [1:0] ld_a  [5] = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd0};
  logic [31:0] ld_exp [5] = '{32'hFFFFFF80, 32'h0000007F, 32'hFFFF80FF, 32'h00007F01, 32'h80FF7F01};

  initial begin
    model_reset();
    #12;
    check("reset_wb_we", 32'(wb_we), 32'd0);
    check("reset_wb_rd", 32'(wb_rd), 32'd0);
    check("reset_wb_data", wb_data, 32'd0);
    check("reset_busy", busy_mask, 32'd0);
    @(posedge clk); #1;
    rst_n = 1;

    // ALU writes and an x0 ALU write.
    alu_valid = 1; alu_rd = 5; alu_data = 32'h1234;
    step();
    check("alu_wb_data", wb_data, 32'h1234);
    alu_rd = 0; alu_data = 32'h5678;
    step();
    check("alu_x0_we", 32'(wb_we), 32'd0);
    alu_valid = 0;

    // Load formatting.
    for (int i = 0; i < 5; i++) begin
      lsu_valid = 1; lsu_rd = 5'(10 + i); lsu_data = 32'h80FF7F01;
      lsu_funct3 = ld_f3[i]; lsu_addr_lo = ld_a[i];
      step();
      check("load_fmt", wb_data, ld_exp[i]);
    end
    lsu_valid = 0;

    // Scoreboard set, clear, and set-wins-over-clear.
    issue_valid = 1; issue_rd = 7;
    step();
    check("sb_set7", 32'(busy_mask[7]), 32'd1);
    issue_valid = 0; lsu_valid = 1; lsu_rd = 7; lsu_funct3 = 3'd2; lsu_data = 32'hCAFE0007;
    step();
    check("sb_clr7", 32'(busy_mask[7]), 32'd0);
    issue_valid = 1; issue_rd = 7; lsu_valid = 0;
    step();
    issue_valid = 1; issue_rd = 7; lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h77;
    step();
    check("sb_set_wins", 32'(busy_mask[7]), 32'd1);
    check("sb_set_wins_we", 32'(wb_rd), 32'd7);
    idle_inputs();
    step();

    // LSU/MDU alternation with ALU idle.
    last_winner = 0;
    for (int i = 0; i < 8; i++) begin
      next_inputs(1);
      step();
    end
    idle_inputs();
    step();

    // ALU starvation of a waiting MDU result.
    alu_valid = 1; alu_rd = 3; mdu_valid = 1; mdu_rd = 4; mdu_data = 32'hD1D1;
    for (int i = 0; i < 4; i++) begin
      alu_data = 32'(100 + i);
      step();
      check("starve_alu_wins", 32'(wb_rd), 32'd3);
    end
    alu_data = 32'hA5A5;
    #1;
    check("starve_force_mdu", 32'(mdu_ready), 32'd1);
    check("starve_force_stall", 32'(alu_stall), 32'd1);
    step();
    check("starve_mdu_written", wb_data, 32'hD1D1);
    mdu_valid = 0;
    step();
    check("starve_alu_held", wb_data, 32'hA5A5);
    alu_valid = 0;
    step();

    // Randomized traffic.
    last_winner = 0;
    for (int i = 0; i < 400; i++) begin
      next_inputs(0);
      step();
    end

    // Reset in the middle of a grant.
    idle_inputs();
    alu_valid = 1; alu_rd = 9; alu_data = 32'hBEEF;
    issue_valid = 1; issue_rd = 12;
    step();
    #2;
    rst_n = 0;
    #1;
    check("midrst_we", 32'(wb_we), 32'd0);
    check("midrst_busy", busy_mask, 32'd0);
    model_reset();
    idle_inputs();
    @(posedge clk); #1;
    rst_n = 1;
    step();
    step();
    check("postrst_we", 32'(wb_we), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
